wb_stream_loader: RTL and testbench

Byte-stream writer for the ternary weight buffer: accepts conv2 weights, bias and alpha scales as an 8-bit valid/ready stream, assembles them into the wide buses the weight buffer captures, then issues the single-cycle `wb_load` strobe. It sits between the host/DMA byte source and the weight buffer, and replaces direct testbench driving of the wide weight inputs.

---
 rtl/wb_stream_loader_pkg.sv | 26 ++
 rtl/wb_stream_loader_router.sv | 29 ++
 rtl/wb_stream_loader.sv | 192 +++++++++++++++++++
 tb/tb_wb_stream_loader.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_stream_loader_pkg.sv
// Shared types and frame layout for the weight-buffer byte-stream loader.
package wb_stream_loader_pkg;

  localparam int unsigned W_BYTES     = 25;
  localparam int unsigned N_WEIGHTS   = 9;
  localparam int unsigned B_BYTES     = 3;
  localparam int unsigned N_ALPHA     = 3;
  localparam int unsigned FRAME_BYTES = 231;
  localparam int unsigned B_OFFSET    = N_WEIGHTS * W_BYTES;
  localparam int unsigned A_OFFSET    = B_OFFSET + B_BYTES;
  localparam int unsigned CNT_W       = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_COMMIT,
    ST_DONE,
    ST_ERR
  } state_t;

  // Byte 0 is the most significant lane so it lands on index [0:7] of an ascending bus.
  typedef logic [0:W_BYTES-1][7:0] wvec_t;
  typedef logic [0:B_BYTES-1][7:0] bvec_t;

endpackage

// File: rtl/wb_stream_loader_router.sv
// Decodes the frame byte counter into per-byte write enables for each segment.
module wb_byte_router
  import wb_stream_loader_pkg::*;
(
  input  logic [CNT_W-1:0]                    cnt,
  input  logic                                wr_en,
  output logic [N_WEIGHTS-1:0][W_BYTES-1:0]   w_we_c,
  output logic [B_BYTES-1:0]                  b_we_c,
  output logic [N_ALPHA-1:0]                  a_we_c
);

  always_comb begin
    w_we_c = '0;
    b_we_c = '0;
    a_we_c = '0;
    for (int i = 0; i < N_WEIGHTS; i++) begin
      for (int j = 0; j < W_BYTES; j++) begin
        w_we_c[i][j] = wr_en && (cnt == CNT_W'(i * W_BYTES + j));
      end
    end
    for (int k = 0; k < B_BYTES; k++) begin
      b_we_c[k] = wr_en && (cnt == CNT_W'(B_OFFSET + k));
    end
    for (int k = 0; k < N_ALPHA; k++) begin
      a_we_c[k] = wr_en && (cnt == CNT_W'(A_OFFSET + k));
    end
  end

endmodule

// File: rtl/wb_stream_loader.sv
// Assembles a 231-byte stream into weight/bias/alpha buses and strobes wb_load.
// Define WB_LOADER_CHKSUM_EN to require a trailing XOR checksum byte per frame.
module wb_stream_loader
  import wb_stream_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [7:0]   s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic         wb_load,
  output logic [0:199] w_211,
  output logic [0:199] w_212,
  output logic [0:199] w_213,
  output logic [0:199] w_221,
  output logic [0:199] w_222,
  output logic [0:199] w_223,
  output logic [0:199] w_231,
  output logic [0:199] w_232,
  output logic [0:199] w_233,
  output logic [0:23]  b_2,
  output logic [7:0]   alpha_1,
  output logic [7:0]   alpha_2,
  output logic [7:0]   alpha_3,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int unsigned IDLE_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BYTES - 1);

  state_t               state_q, state_nxt;
  logic [CNT_W-1:0]     cnt_q, cnt_nxt;
  logic [IDLE_W-1:0]    idle_q, idle_nxt;
  logic                 s_ready_nxt, wb_load_nxt, busy_nxt, done_nxt, err_nxt;
  logic                 accept_c, timeout_c, wr_en_c, frame_start_c;

  logic [N_WEIGHTS-1:0][W_BYTES-1:0] w_we_c;
  logic [B_BYTES-1:0]                b_we_c;
  logic [N_ALPHA-1:0]                a_we_c;

  wvec_t       w_q [N_WEIGHTS];
  bvec_t       b_q;
  logic [7:0]  a_q [N_ALPHA];

  assign accept_c      = s_valid && s_ready;
  assign wr_en_c       = accept_c && (state_q == ST_LOAD);
  assign frame_start_c = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));
  assign timeout_c     = (TIMEOUT_CYC != 0) && !accept_c && (idle_q == IDLE_W'(TIMEOUT_CYC - 1));

`ifdef WB_LOADER_CHKSUM_EN
  logic [7:0] chk_q;

  // Running XOR of payload bytes, compared against the trailing checksum byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_q <= '0;
    end else if (frame_start_c) begin
      chk_q <= '0;
    end else if (wr_en_c) begin
      chk_q <= chk_q ^ s_data;
    end
  end
`endif

  always_comb begin
    state_nxt   = state_q;
    cnt_nxt     = cnt_q;
    idle_nxt    = idle_q;
    s_ready_nxt = 1'b0;
    wb_load_nxt = 1'b0;
    busy_nxt    = 1'b0;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (frame_start_c) begin
          state_nxt = ST_LOAD;
          cnt_nxt   = '0;
          idle_nxt  = '0;
        end
      end
      ST_LOAD: begin
        if (accept_c) begin
          cnt_nxt  = cnt_q + 1'b1;
          idle_nxt = '0;
          if (cnt_q == LAST_CNT) begin
`ifdef WB_LOADER_CHKSUM_EN
            state_nxt = ST_CHECK;
`else
            state_nxt = ST_COMMIT;
`endif
          end
        end else begin
          idle_nxt = idle_q + 1'b1;
          if (timeout_c) state_nxt = ST_ERR;
        end
      end
      ST_CHECK: begin
`ifdef WB_LOADER_CHKSUM_EN
        if (accept_c) begin
          idle_nxt  = '0;
          state_nxt = (s_data == chk_q) ? ST_COMMIT : ST_ERR;
        end else begin
          idle_nxt = idle_q + 1'b1;
          if (timeout_c) state_nxt = ST_ERR;
        end
`else
        state_nxt = ST_IDLE;
`endif
      end
      ST_COMMIT: state_nxt = ST_DONE;
      default:   state_nxt = ST_IDLE;
    endcase
    // Status outputs are registered decodes of the next state.
    s_ready_nxt = (state_nxt == ST_LOAD) || (state_nxt == ST_CHECK);
    wb_load_nxt = (state_nxt == ST_COMMIT);
    busy_nxt    = s_ready_nxt || wb_load_nxt;
    done_nxt    = (state_nxt == ST_DONE);
    err_nxt     = (state_nxt == ST_ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idle_q  <= '0;
      s_ready <= 1'b0;
      wb_load <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      idle_q  <= idle_nxt;
      s_ready <= s_ready_nxt;
      wb_load <= wb_load_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      err     <= err_nxt;
    end
  end

  wb_byte_router u_router (
    .cnt    (cnt_q),
    .wr_en  (wr_en_c),
    .w_we_c (w_we_c),
    .b_we_c (b_we_c),
    .a_we_c (a_we_c)
  );

  // Byte storage updates live; untouched bytes keep the previous frame's value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_WEIGHTS; i++) w_q[i] <= '0;
      b_q <= '0;
      for (int k = 0; k < N_ALPHA; k++) a_q[k] <= '0;
    end else begin
      for (int i = 0; i < N_WEIGHTS; i++) begin
        for (int j = 0; j < W_BYTES; j++) begin
          if (w_we_c[i][j]) w_q[i][j] <= s_data;
        end
      end
      for (int k = 0; k < B_BYTES; k++) begin
        if (b_we_c[k]) b_q[k] <= s_data;
      end
      for (int k = 0; k < N_ALPHA; k++) begin
        if (a_we_c[k]) a_q[k] <= s_data;
      end
    end
  end

  assign w_211   = w_q[0];
  assign w_212   = w_q[1];
  assign w_213   = w_q[2];
  assign w_221   = w_q[3];
  assign w_222   = w_q[4];
  assign w_223   = w_q[5];
  assign w_231   = w_q[6];
  assign w_232   = w_q[7];
  assign w_233   = w_q[8];
  assign b_2     = b_q;
  assign alpha_1 = a_q[0];
  assign alpha_2 = a_q[1];
  assign alpha_3 = a_q[2];

endmodule

// File: tb/tb_wb_stream_loader.sv
// Randomized self-checking bench for wb_stream_loader against a byte-image reference model.
module tb_wb_stream_loader;

  localparam int PB = 231;
`ifdef WB_LOADER_CHKSUM_EN
  localparam int FB = 232;
`else
  localparam int FB = 231;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [7:0]   s_data = 8'h00;
  logic         s_valid = 1'b0;
  logic         s_ready, wb_load, busy, done, err;
  logic [0:199] w_211, w_212, w_213, w_221, w_222, w_223, w_231, w_232, w_233;
  logic [0:23]  b_2;
  logic [7:0]   alpha_1, alpha_2, alpha_3;

  int errors = 0;
  int checks = 0;
  int load_pulses = 0;

  logic [7:0] frame [232];
  logic [7:0] exp_mem [PB];

  wb_stream_loader #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .wb_load(wb_load),
    .w_211(w_211), .w_212(w_212), .w_213(w_213), .w_221(w_221), .w_222(w_222),
    .w_223(w_223), .w_231(w_231), .w_232(w_232), .w_233(w_233),
    .b_2(b_2), .alpha_1(alpha_1), .alpha_2(alpha_2), .alpha_3(alpha_3),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wb_load === 1'b1) load_pulses++;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // Byte at frame position idx as seen on the DUT buses (bit 7 at the lowest bus index).
  function automatic logic [7:0] bus_byte(input int idx);
    logic [0:199] v;
    logic [7:0]   r;
    int           k;
    r = 8'h00;
    if (idx < 225) begin
      case (idx / 25)
        0: v = w_211;  1: v = w_212;  2: v = w_213;
        3: v = w_221;  4: v = w_222;  5: v = w_223;
        6: v = w_231;  7: v = w_232;  default: v = w_233;
      endcase
      k = idx % 25;
      r = v[8*k +: 8];
    end else if (idx < 228) begin
      k = idx - 225;
      r = b_2[8*k +: 8];
    end else if (idx == 228) r = alpha_1;
    else if (idx == 229) r = alpha_2;
    else r = alpha_3;
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic make_frame(input bit incrementing);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < PB; i++) begin
      frame[i] = incrementing ? 8'(i) : 8'($urandom_range(0, 255));
      x = x ^ frame[i];
    end
    frame[231] = x;
  endtask

  task automatic do_start;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (s_ready !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL start: s_ready=%b busy=%b done=%b err=%b, required 1 1 0 0", s_ready, busy, done, err);
    end
  endtask

  // mode 0: back-to-back, 1: valid every other cycle, 2: random gaps well under the timeout
  task automatic stream(input int first, input int last, input int mode, output int cycles);
    int  idx;
    int  run;
    logic v;
    idx = first;
    cycles = 0;
    run = 0;
    while (idx < last && cycles < 4000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cycles % 2 == 0);
        default: v = (run >= 8) || ($urandom_range(0, 3) != 0);
      endcase
      run = v ? 0 : run + 1;
      s_valid = v;
      s_data = frame[idx];
      if (v && s_ready === 1'b1) begin
        if (idx < PB) exp_mem[idx] = frame[idx];
        idx++;
      end
      tick();
      cycles++;
    end
    s_valid = 1'b0;
    checks++;
    if (idx != last) begin
      errors++;
      $display("FAIL stream_budget: accepted up to %0d, required %0d", idx, last);
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < PB; i++) exp_mem[i] = 8'h00;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({s_ready, wb_load, busy, done, err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, required 00000", {s_ready, wb_load, busy, done, err});
    end
    for (int i = 0; i < PB; i++) begin
      checks++;
      if (bus_byte(i) !== exp_mem[i]) begin
        errors++;
        $display("FAIL reset_bus byte %0d: got %h, required %h", i, bus_byte(i), exp_mem[i]);
      end
    end
  endtask

  task automatic test_incrementing;
    int cyc;
    int p0;
    make_frame(1'b1);
    p0 = load_pulses;
    do_start();
    stream(0, FB, 0, cyc);
    checks++;
    if (cyc != FB) begin errors++; $display("FAIL incr_len: %0d cycles, required %0d", cyc, FB); end
    checks++;
    if (wb_load !== 1'b1 || load_pulses != p0) begin
      errors++; $display("FAIL incr_load: wb_load=%b pulses=%0d, required 1 and %0d", wb_load, load_pulses, p0);
    end
    checks++;
    if (w_211[0:7] !== 8'h00 || w_211[8:15] !== 8'h01 || w_212[0:7] !== 8'h19) begin
      errors++; $display("FAIL incr_w: w_211[0:15]=%h w_212[0:7]=%h, required 0001 19", w_211[0:15], w_212[0:7]);
    end
    checks++;
    if (b_2 !== 24'hE1E2E3 || alpha_3 !== 8'hE6) begin
      errors++; $display("FAIL incr_b_alpha: b_2=%h alpha_3=%h, required e1e2e3 e6", b_2, alpha_3);
    end
    for (int i = 0; i < PB; i++) begin
      checks++;
      if (bus_byte(i) !== exp_mem[i]) begin
        errors++; $display("FAIL incr_bus byte %0d: got %h, required %h", i, bus_byte(i), exp_mem[i]);
      end
    end
    tick();
    checks++;
    if (wb_load !== 1'b0 || done !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b0 || load_pulses != p0 + 1) begin
      errors++;
      $display("FAIL incr_done: wb_load=%b done=%b busy=%b s_ready=%b pulses=%0d, required 0 1 0 0 %0d",
               wb_load, done, busy, s_ready, load_pulses, p0 + 1);
    end
  endtask

  task automatic test_toggle_valid;
    int cyc;
    int p0;
    make_frame(1'b1);
    p0 = load_pulses;
    do_start();
    stream(0, FB, 1, cyc);
    checks++;
    if (cyc != 2 * FB - 1 || wb_load !== 1'b1 || load_pulses != p0) begin
      errors++;
      $display("FAIL toggle_load: cycles=%0d wb_load=%b pulses=%0d, required %0d 1 %0d", cyc, wb_load, load_pulses, 2 * FB - 1, p0);
    end
    for (int i = 0; i < PB; i++) begin
      checks++;
      if (bus_byte(i) !== exp_mem[i]) begin
        errors++; $display("FAIL toggle_bus byte %0d: got %h, required %h", i, bus_byte(i), exp_mem[i]);
      end
    end
    tick();
    checks++;
    if (done !== 1'b1 || load_pulses != p0 + 1) begin
      errors++; $display("FAIL toggle_done: done=%b pulses=%0d, required 1 %0d", done, load_pulses, p0 + 1);
    end
  endtask

  task automatic test_random_frames;
    int cyc;
    int p0;
    for (int f = 0; f < 3; f++) begin
      make_frame(1'b0);
      p0 = load_pulses;
      do_start();
      stream(0, FB, 2, cyc);
      checks++;
      if (wb_load !== 1'b1 || err !== 1'b0) begin
        errors++; $display("FAIL rand_load frame %0d: wb_load=%b err=%b, required 1 0", f, wb_load, err);
      end
      for (int i = 0; i < PB; i++) begin
        checks++;
        if (bus_byte(i) !== exp_mem[i]) begin
          errors++; $display("FAIL rand_bus frame %0d byte %0d: got %h, required %h", f, i, bus_byte(i), exp_mem[i]);
        end
      end
      tick();
      checks++;
      if (done !== 1'b1 || load_pulses != p0 + 1) begin
        errors++; $display("FAIL rand_done frame %0d: done=%b pulses=%0d, required 1 %0d", f, done, load_pulses, p0 + 1);
      end
    end
  endtask

  task automatic test_timeout;
    int cyc;
    int p0;
    int n;
    make_frame(1'b0);
    p0 = load_pulses;
    do_start();
    stream(0, 100, 0, cyc);
    repeat (15) tick();
    checks++;
    if (err !== 1'b0 || s_ready !== 1'b1) begin
      errors++; $display("FAIL timeout_15idle: err=%b s_ready=%b, required 0 1", err, s_ready);
    end
    stream(100, 150, 0, cyc);
    n = 0;
    while (err !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n != 16) begin errors++; $display("FAIL timeout_count: err after %0d idle cycles, required 16", n); end
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0 || load_pulses != p0) begin
      errors++;
      $display("FAIL timeout_state: done=%b busy=%b s_ready=%b pulses=%0d, required 0 0 0 %0d", done, busy, s_ready, load_pulses, p0);
    end
    for (int i = 0; i < PB; i++) begin
      checks++;
      if (bus_byte(i) !== exp_mem[i]) begin
        errors++; $display("FAIL timeout_bus byte %0d: got %h, required %h", i, bus_byte(i), exp_mem[i]);
      end
    end
    make_frame(1'b0);
    do_start();
    stream(0, FB, 0, cyc);
    tick();
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || load_pulses != p0 + 1) begin
      errors++; $display("FAIL timeout_recover: done=%b err=%b pulses=%0d, required 1 0 %0d", done, err, load_pulses, p0 + 1);
    end
  endtask

  task automatic test_start_ignored;
    int cyc;
    int p0;
    make_frame(1'b0);
    p0 = load_pulses;
    do_start();
    stream(0, 50, 0, cyc);
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (s_ready !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL start_ign_state: s_ready=%b busy=%b, required 1 1", s_ready, busy);
    end
    stream(50, FB, 0, cyc);
    checks++;
    if (wb_load !== 1'b1 || load_pulses != p0) begin
      errors++; $display("FAIL start_ign_load: wb_load=%b pulses=%0d, required 1 %0d", wb_load, load_pulses, p0);
    end
    for (int i = 0; i < PB; i++) begin
      checks++;
      if (bus_byte(i) !== exp_mem[i]) begin
        errors++; $display("FAIL start_ign_bus byte %0d: got %h, required %h", i, bus_byte(i), exp_mem[i]);
      end
    end
    tick();
  endtask

  task automatic test_reset_mid;
    int cyc;
    int p0;
    make_frame(1'b0);
    do_start();
    stream(0, 120, 0, cyc);
    p0 = load_pulses;
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < PB; i++) exp_mem[i] = 8'h00;
    checks++;
    if ({s_ready, wb_load, busy, done, err} !== 5'b0) begin
      errors++; $display("FAIL rstmid_ctrl: got %b, required 00000", {s_ready, wb_load, busy, done, err});
    end
    for (int i = 0; i < PB; i++) begin
      checks++;
      if (bus_byte(i) !== exp_mem[i]) begin
        errors++; $display("FAIL rstmid_bus byte %0d: got %h, required %h", i, bus_byte(i), exp_mem[i]);
      end
    end
    tick();
    rst_n = 1'b1;
    s_valid = 1'b1;
    tick();
    tick();
    s_valid = 1'b0;
    checks++;
    if (s_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || load_pulses != p0) begin
      errors++;
      $display("FAIL rstmid_idle: s_ready=%b busy=%b done=%b pulses=%0d, required 0 0 0 %0d", s_ready, busy, done, load_pulses, p0);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    int p0;
    p0 = load_pulses;
    for (int f = 0; f < 2; f++) begin
      make_frame(1'b0);
      do_start();
      stream(0, FB, 0, cyc);
      checks++;
      if (wb_load !== 1'b1) begin errors++; $display("FAIL b2b_load frame %0d: wb_load=%b, required 1", f, wb_load); end
      for (int i = 0; i < PB; i++) begin
        checks++;
        if (bus_byte(i) !== exp_mem[i]) begin
          errors++; $display("FAIL b2b_bus frame %0d byte %0d: got %h, required %h", f, i, bus_byte(i), exp_mem[i]);
        end
      end
      tick();
      checks++;
      if (done !== 1'b1) begin errors++; $display("FAIL b2b_done frame %0d: done=%b, required 1", f, done); end
    end
    checks++;
    if (load_pulses != p0 + 2) begin
      errors++; $display("FAIL b2b_pulses: %0d, required %0d", load_pulses, p0 + 2);
    end
  endtask

`ifdef WB_LOADER_CHKSUM_EN
  task automatic test_checksum;
    int cyc;
    int p0;
    make_frame(1'b0);
    frame[231] = frame[231] ^ 8'h01;
    p0 = load_pulses;
    do_start();
    stream(0, FB, 0, cyc);
    checks++;
    if (wb_load !== 1'b0 || err !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL chk_bad: wb_load=%b err=%b busy=%b, required 0 1 0", wb_load, err, busy);
    end
    tick();
    checks++;
    if (load_pulses != p0 || done !== 1'b0) begin
      errors++; $display("FAIL chk_bad_pulses: pulses=%0d done=%b, required %0d 0", load_pulses, done, p0);
    end
    make_frame(1'b0);
    do_start();
    stream(0, FB, 0, cyc);
    checks++;
    if (wb_load !== 1'b1) begin errors++; $display("FAIL chk_good: wb_load=%b, required 1", wb_load); end
    tick();
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || load_pulses != p0 + 1) begin
      errors++; $display("FAIL chk_good_done: done=%b err=%b pulses=%0d, required 1 0 %0d", done, err, load_pulses, p0 + 1);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_incrementing();
    test_toggle_valid();
    test_random_frames();
    test_timeout();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
`ifdef WB_LOADER_CHKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
